// File: rtl/riscv_i32_trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_i32_trace_capture_ctrl
// Purpose  : Trace capture controller for a small circular buffer fed by the
//            RISC-V i32 retirement trace. Arms capture, records retired
//            instructions, detects a trigger (breakpoint or PC match), stops
//            after a programmable post-trigger count and reads the buffer out
//            oldest-first over a valid/ready handshake.
// Ports    : clk, clk__enable, reset_n       - clock, global enable, async reset
//            riscv_clk_enable, trace__*      - trace input and capture qualifier
//            ctl_*                           - arm/stop/trigger/post-count control
//            rd_start, rd_valid/ready/data/last - readout handshake
//            status_state/count/wrapped      - controller status
// Revision : 1.0 - initial release
// ============================================================================
module riscv_i32_trace_capture_ctrl #(
  parameter int LOG_DEPTH = 4,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 clk__enable,
  input  logic                 reset_n,
  input  logic                 riscv_clk_enable,
  input  logic                 trace__instr_valid,
  input  logic [31:0]          trace__instr_pc,
  input  logic                 trace__branch_taken,
  input  logic                 trace__trap,
  input  logic                 trace__ret,
  input  logic                 trace__jalr,
  input  logic                 trace__bkpt_valid,
  input  logic                 ctl_arm,
  input  logic                 ctl_stop,
  input  logic                 ctl_trig_pc_en,
  input  logic [31:0]          ctl_trig_pc,
  input  logic [LOG_DEPTH:0]   ctl_post_count,
  input  logic                 rd_start,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [35:0]          rd_data,
  output logic                 rd_last,
  output logic [2:0]           status_state,
  output logic [LOG_DEPTH:0]   status_count,
  output logic                 status_wrapped
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_TRIGGERED = 3'd2,
    ST_DONE      = 3'd3,
    ST_READOUT   = 3'd4
  } state_t;

  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_TWO  = (LOG_DEPTH+1)'(2);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  state_t                 state;
  logic [LOG_DEPTH-1:0]   wr_ptr;
  logic [LOG_DEPTH-1:0]   rd_ptr;
  logic [LOG_DEPTH:0]     count;
  logic [LOG_DEPTH:0]     post_cnt;
  logic [LOG_DEPTH:0]     remaining;
  logic                   wrapped;
  logic [35:0]            mem [DEPTH];

  logic                   capture;
  logic                   trig_hit;
  logic [35:0]            record;
  logic [LOG_DEPTH-1:0]   start_ptr;
  logic [LOG_DEPTH-1:0]   next_rd_ptr;

  // A stop or arm in the same cycle takes precedence over writing the record:
  // stop freezes the buffer, arm discards it.
  assign capture = clk__enable & riscv_clk_enable & trace__instr_valid &
                   (((state == ST_ARMED) & ~ctl_stop & ~ctl_arm) |
                    ((state == ST_TRIGGERED) & ~ctl_stop));

  assign trig_hit    = trace__bkpt_valid | (ctl_trig_pc_en & (trace__instr_pc == ctl_trig_pc));
  assign record      = {trace__instr_pc, trace__branch_taken, trace__trap, trace__ret, trace__jalr};
  // Once wrapped, the oldest surviving record sits at the write pointer.
  assign start_ptr   = wrapped ? wr_ptr : '0;
  assign next_rd_ptr = rd_ptr + PTR_ONE;

  // Buffer storage carries no reset; contents are only meaningful via count.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= record;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      remaining <= '0;
      wrapped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else if (clk__enable) begin
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (count == CNT_FULL) begin
          wrapped <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end

      case (state)
        ST_IDLE: begin
          if (ctl_arm) begin
            state   <= ST_ARMED;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (ctl_stop) begin
            state <= ST_DONE;
          end else if (ctl_arm) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
          end else if (capture && trig_hit) begin
            post_cnt <= ctl_post_count;
            state    <= (ctl_post_count == '0) ? ST_DONE : ST_TRIGGERED;
          end
        end

        ST_TRIGGERED: begin
          if (ctl_stop) begin
            state <= ST_DONE;
          end else if (capture) begin
            post_cnt <= post_cnt - CNT_ONE;
            if (post_cnt == CNT_ONE) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (ctl_arm) begin
            state   <= ST_ARMED;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
          end else if (rd_start) begin
            if (count == '0) begin
              state <= ST_IDLE;
            end else begin
              // Present the first record on the edge that accepts rd_start.
              state     <= ST_READOUT;
              rd_ptr    <= start_ptr;
              remaining <= count;
              rd_data   <= mem[start_ptr];
              rd_valid  <= 1'b1;
              rd_last   <= (count == CNT_ONE);
            end
          end
        end

        ST_READOUT: begin
          if (rd_valid && rd_ready) begin
            if (remaining == CNT_ONE) begin
              state     <= ST_IDLE;
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              remaining <= '0;
              count     <= '0;
            end else begin
              rd_ptr    <= next_rd_ptr;
              remaining <= remaining - CNT_ONE;
              rd_data   <= mem[next_rd_ptr];
              rd_last   <= (remaining == CNT_TWO);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign status_state   = state;
  assign status_count   = count;
  assign status_wrapped = wrapped;

endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_i32_trace_capture_ctrl
// Purpose  : Scoreboard bench for riscv_i32_trace_capture_ctrl. Directed
//            stimulus pushes expected readout records into a queue; a monitor
//            on the falling edge compares every presented record against the
//            queue head and pops it on each accepted transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_i32_trace_capture_ctrl;

  localparam int LOG_DEPTH = 4;
  localparam int DEPTH     = 16;

  logic                 clk = 1'b0;
  logic                 clk__enable;
  logic                 reset_n;
  logic                 riscv_clk_enable;
  logic                 trace__instr_valid;
  logic [31:0]          trace__instr_pc;
  logic                 trace__branch_taken;
  logic                 trace__trap;
  logic                 trace__ret;
  logic                 trace__jalr;
  logic                 trace__bkpt_valid;
  logic                 ctl_arm;
  logic                 ctl_stop;
  logic                 ctl_trig_pc_en;
  logic [31:0]          ctl_trig_pc;
  logic [LOG_DEPTH:0]   ctl_post_count;
  logic                 rd_start;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [35:0]          rd_data;
  logic                 rd_last;
  logic [2:0]           status_state;
  logic [LOG_DEPTH:0]   status_count;
  logic                 status_wrapped;

  riscv_i32_trace_capture_ctrl #(.LOG_DEPTH(LOG_DEPTH), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .clk__enable         (clk__enable),
    .reset_n             (reset_n),
    .riscv_clk_enable    (riscv_clk_enable),
    .trace__instr_valid  (trace__instr_valid),
    .trace__instr_pc     (trace__instr_pc),
    .trace__branch_taken (trace__branch_taken),
    .trace__trap         (trace__trap),
    .trace__ret          (trace__ret),
    .trace__jalr         (trace__jalr),
    .trace__bkpt_valid   (trace__bkpt_valid),
    .ctl_arm             (ctl_arm),
    .ctl_stop            (ctl_stop),
    .ctl_trig_pc_en      (ctl_trig_pc_en),
    .ctl_trig_pc         (ctl_trig_pc),
    .ctl_post_count      (ctl_post_count),
    .rd_start            (rd_start),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_data             (rd_data),
    .rd_last             (rd_last),
    .status_state        (status_state),
    .status_count        (status_count),
    .status_wrapped      (status_wrapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [35:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   xfers = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [3:0] flags, input logic last);
    exp_t e;
    e.data = {pc, flags};
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, mid-cycle between posedges.
  always @(negedge clk) begin
    if (reset_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 64'(rd_valid), 64'(0));
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_q[0].data));
        chk("rd_last", 64'(rd_last), 64'(exp_q[0].last));
        if (rd_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    ctl_arm = 1'b1; tick(); ctl_arm = 1'b0;
  endtask

  task automatic pulse_stop();
    ctl_stop = 1'b1; tick(); ctl_stop = 1'b0;
  endtask

  task automatic pulse_rd_start();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
  endtask

  task automatic capture(input logic [31:0] pc, input logic [3:0] flags, input logic bkpt);
    trace__instr_valid  = 1'b1;
    trace__instr_pc     = pc;
    {trace__branch_taken, trace__trap, trace__ret, trace__jalr} = flags;
    trace__bkpt_valid   = bkpt;
    tick();
    trace__instr_valid  = 1'b0;
    trace__bkpt_valid   = 1'b0;
    {trace__branch_taken, trace__trap, trace__ret, trace__jalr} = 4'b0;
  endtask

  // Wait for the scoreboard to empty, then one more edge for the DUT to settle.
  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({nm, "_drain_timeout"}, 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    logic [3:0] pat;
    int         x0;

    clk__enable = 1'b1; reset_n = 1'b0; riscv_clk_enable = 1'b1;
    trace__instr_valid = 1'b0; trace__instr_pc = '0;
    {trace__branch_taken, trace__trap, trace__ret, trace__jalr} = 4'b0;
    trace__bkpt_valid = 1'b0; ctl_arm = 1'b0; ctl_stop = 1'b0;
    ctl_trig_pc_en = 1'b0; ctl_trig_pc = '0; ctl_post_count = '0;
    rd_start = 1'b0; rd_ready = 1'b0;

    #12;
    chk("rst_state", 64'(status_state), 64'(0));
    chk("rst_count", 64'(status_count), 64'(0));
    chk("rst_wrapped", 64'(status_wrapped), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_last", 64'(rd_last), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    reset_n = 1'b1;
    tick();

    // 1: five records, stop, full readout.
    pulse_arm();
    chk("t1_armed", 64'(status_state), 64'(1));
    for (int i = 0; i < 5; i++) begin
      capture(32'h100 + 32'(4*i), 4'(i), 1'b0);
      push_exp(32'h100 + 32'(4*i), 4'(i), i == 4);
    end
    pulse_stop();
    chk("t1_done", 64'(status_state), 64'(3));
    chk("t1_count", 64'(status_count), 64'(5));
    rd_ready = 1'b1;
    pulse_rd_start();
    chk("t1_readout", 64'(status_state), 64'(4));
    drain("t1");
    chk("t1_idle", 64'(status_state), 64'(0));
    chk("t1_count0", 64'(status_count), 64'(0));
    chk("t1_valid0", 64'(rd_valid), 64'(0));

    // 2: PC-match trigger at 0x200 with three post-trigger records.
    ctl_trig_pc_en = 1'b1; ctl_trig_pc = 32'h200; ctl_post_count = 5'd3;
    pulse_arm();
    for (int i = 0; i < 12; i++) begin
      capture(32'h1F0 + 32'(4*i), 4'b0, 1'b0);
      if (i == 4) chk("t2_trig", 64'(status_state), 64'(2));
      if (i == 6) chk("t2_still_trig", 64'(status_state), 64'(2));
      if (i == 7) chk("t2_done_0x20c", 64'(status_state), 64'(3));
    end
    ctl_trig_pc_en = 1'b0; ctl_post_count = '0;
    chk("t2_count", 64'(status_count), 64'(8));
    for (int i = 0; i < 8; i++) push_exp(32'h1F0 + 32'(4*i), 4'b0, i == 7);
    pulse_rd_start();
    drain("t2");
    chk("t2_idle", 64'(status_state), 64'(0));

    // 3: 20 records into a 16-deep buffer.
    pulse_arm();
    for (int i = 0; i < 20; i++) capture(32'(4*i), 4'(i), 1'b0);
    pulse_stop();
    chk("t3_wrapped", 64'(status_wrapped), 64'(1));
    chk("t3_count", 64'(status_count), 64'(16));
    for (int i = 4; i < 20; i++) push_exp(32'(4*i), 4'(i), i == 19);
    pulse_rd_start();
    drain("t3");
    chk("t3_idle", 64'(status_state), 64'(0));

    // 4: readout with ready pattern 1,0,0,1,...
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      capture(32'h300 + 32'(4*i), 4'(4'hF - i), 1'b0);
      push_exp(32'h300 + 32'(4*i), 4'(4'hF - i), i == 3);
    end
    pulse_stop();
    x0 = xfers;
    rd_ready = 1'b0;
    pulse_rd_start();
    pat = 4'b1001;
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0) break;
      rd_ready = pat[c % 4];
      tick();
    end
    rd_ready = 1'b1;
    drain("t4");
    chk("t4_xfers", 64'(xfers - x0), 64'(4));
    chk("t4_idle", 64'(status_state), 64'(0));

    // 5: capture qualifiers, then breakpoint trigger with zero post count.
    pulse_arm();
    capture(32'h400, 4'b0101, 1'b0);
    riscv_clk_enable = 1'b0;
    capture(32'h500, 4'b0, 1'b0);
    riscv_clk_enable = 1'b1;
    chk("t5_no_riscv_en", 64'(status_count), 64'(1));
    clk__enable = 1'b0;
    capture(32'h504, 4'b0, 1'b1);
    clk__enable = 1'b1;
    chk("t5_no_clk_en_cnt", 64'(status_count), 64'(1));
    chk("t5_no_clk_en_st", 64'(status_state), 64'(1));
    capture(32'h404, 4'b0010, 1'b1);
    chk("t5_bkpt_done", 64'(status_state), 64'(3));
    chk("t5_bkpt_count", 64'(status_count), 64'(2));
    push_exp(32'h400, 4'b0101, 1'b0);
    push_exp(32'h404, 4'b0010, 1'b1);
    pulse_rd_start();
    drain("t5");

    // 6: async reset in the middle of a readout.
    pulse_arm();
    for (int i = 0; i < 6; i++) capture(32'h600 + 32'(4*i), 4'b0, 1'b0);
    pulse_stop();
    for (int i = 0; i < 3; i++) push_exp(32'h600 + 32'(4*i), 4'b0, 1'b0);
    x0 = xfers;
    rd_ready = 1'b0;
    pulse_rd_start();
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    #6;
    chk("t6_xfers", 64'(xfers - x0), 64'(2));
    chk("t6_pre_readout", 64'(status_state), 64'(4));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(rd_valid), 64'(0));
    chk("t6_rst_state", 64'(status_state), 64'(0));
    chk("t6_rst_count", 64'(status_count), 64'(0));
    exp_q.delete();
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    chk("t6_post_idle", 64'(status_state), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
